// File: rtl/dsp_mac_pipe.sv
// Pipelined multiply-accumulate slice: optional input and multiplier register
// stages feed a single ALU stage that owns the P accumulator and overflow flag.
module dsp_mac_pipe #(
  parameter int A_W      = 25,
  parameter int B_W      = 18,
  parameter int C_W      = 48,
  parameter int P_W      = 48,
  parameter int AREG     = 1,
  parameter int MREG     = 1,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           in_valid,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  input  logic [C_W-1:0] c,
  input  logic [2:0]     op,
  output logic           out_valid,
  output logic [P_W-1:0] p,
  output logic           ovf
);

  localparam int M_W = A_W + B_W;
  localparam int E_W = P_W + 2;
  localparam bit SGN = (SIGNED != 0);

  typedef struct packed {
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic [C_W-1:0] c;
    logic [2:0]     op;
    logic           v;
  } in_t;

  typedef struct packed {
    logic [M_W-1:0] prod;
    logic [C_W-1:0] c;
    logic [2:0]     op;
    logic           v;
  } mul_t;

  in_t  in_d;
  in_t  in_s;
  mul_t mul_d;
  mul_t mul_s;

  assign in_d = {a, b, c, op, in_valid};

  generate
    if (AREG == 0) begin : g_no_areg
      assign in_s = in_d;
    end else begin : g_areg
      in_t areg_q [AREG];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < AREG; i++) areg_q[i] <= '0;
        end else if (en) begin
          areg_q[0] <= in_d;
          for (int i = 1; i < AREG; i++) areg_q[i] <= areg_q[i-1];
        end
      end
      assign in_s = areg_q[AREG-1];
    end
  endgenerate

  // Extend both operands to the full product width so the low M_W bits of an
  // unsigned multiply equal the signed or unsigned product as configured.
  logic [M_W-1:0] a_x;
  logic [M_W-1:0] b_x;
  logic [M_W-1:0] prod_d;

  assign a_x    = {{B_W{SGN & in_s.a[A_W-1]}}, in_s.a};
  assign b_x    = {{A_W{SGN & in_s.b[B_W-1]}}, in_s.b};
  assign prod_d = a_x * b_x;
  assign mul_d  = {prod_d, in_s.c, in_s.op, in_s.v};

  generate
    if (MREG == 0) begin : g_no_mreg
      assign mul_s = mul_d;
    end else begin : g_mreg
      mul_t mreg_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          mreg_q <= '0;
        end else if (en) begin
          mreg_q <= mul_d;
        end
      end
      assign mul_s = mreg_q;
    end
  endgenerate

  logic [P_W-1:0] p_q;
  logic [P_W-1:0] p_d;
  logic           ovf_q;
  logic           ovf_d;
  logic           out_valid_q;

  logic [E_W-1:0] m_e;
  logic [E_W-1:0] c_e;
  logic [E_W-1:0] p_e;
  logic [E_W-1:0] res;
  logic           out_of_range;

  assign m_e = {{(E_W-M_W){SGN & mul_s.prod[M_W-1]}}, mul_s.prod};
  assign c_e = {{(E_W-C_W){SGN & mul_s.c[C_W-1]}}, mul_s.c};
  assign p_e = {{2{SGN & p_q[P_W-1]}}, p_q};

  always_comb begin
    res = p_e;
    case (mul_s.op)
      3'b000:  res = m_e;
      3'b001:  res = m_e + c_e;
      3'b010:  res = p_e + m_e;
      3'b011:  res = p_e - m_e;
      3'b100:  res = c_e - m_e;
      3'b101:  res = c_e;
      3'b110:  res = '0;
      default: res = p_e;
    endcase
  end

  // E_W bits hold every true result exactly, so range is judged on the top bits.
  always_comb begin
    if (SGN) begin
      out_of_range = !((&res[E_W-1:P_W-1]) || !(|res[E_W-1:P_W-1]));
    end else begin
      out_of_range = |res[E_W-1:P_W];
    end

    p_d   = res[P_W-1:0];
    ovf_d = out_of_range;

    if (out_of_range && (SATURATE != 0)) begin
      if (res[E_W-1]) begin
        p_d = SGN ? {1'b1, {(P_W-1){1'b0}}} : '0;
      end else begin
        p_d = SGN ? {1'b0, {(P_W-1){1'b1}}} : '1;
      end
    end

    if ((mul_s.op == 3'b101) || (mul_s.op == 3'b110)) begin
      ovf_d = 1'b0;
    end
    if (mul_s.op == 3'b111) begin
      p_d   = p_q;
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q         <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (en) begin
      out_valid_q <= mul_s.v;
      if (mul_s.v) begin
        p_q   <= p_d;
        ovf_q <= ovf_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign p         = p_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Bench for dsp_mac_pipe: six configurations share one stimulus stream and are
// checked each cycle against an integer-arithmetic model plus fixed vector tables.
module tb_dsp_mac_pipe;

  localparam int NI = 6;
  localparam int AW_C  [NI] = '{25, 8, 8, 25, 25, 25};
  localparam int BW_C  [NI] = '{18, 8, 8, 18, 18, 18};
  localparam int PW_C  [NI] = '{48, 16, 16, 48, 48, 48};
  localparam int CW_C  [NI] = '{48, 16, 16, 48, 48, 48};
  localparam int SG_C  [NI] = '{1, 1, 1, 0, 1, 1};
  localparam int ST_C  [NI] = '{0, 1, 0, 0, 0, 0};
  localparam int LAT_C [NI] = '{3, 3, 3, 3, 1, 4};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic        vin = 1'b0;
  logic [24:0] a_d = '0;
  logic [17:0] b_d = '0;
  logic [47:0] c_d = '0;
  logic [2:0]  op_d = '0;

  logic [NI-1:0] ov_w;
  logic [NI-1:0] ovf_w;
  logic [47:0]   p0, p3, p4, p5;
  logic [15:0]   p1, p2;

  always #5 clk = ~clk;

  dsp_mac_pipe u0 (
    .clk(clk), .rst(rst), .en(en), .in_valid(vin), .a(a_d), .b(b_d), .c(c_d),
    .op(op_d), .out_valid(ov_w[0]), .p(p0), .ovf(ovf_w[0]));

  dsp_mac_pipe #(.A_W(8), .B_W(8), .C_W(16), .P_W(16), .SATURATE(1)) u1 (
    .clk(clk), .rst(rst), .en(en), .in_valid(vin), .a(a_d[7:0]), .b(b_d[7:0]),
    .c(c_d[15:0]), .op(op_d), .out_valid(ov_w[1]), .p(p1), .ovf(ovf_w[1]));

  dsp_mac_pipe #(.A_W(8), .B_W(8), .C_W(16), .P_W(16), .SATURATE(0)) u2 (
    .clk(clk), .rst(rst), .en(en), .in_valid(vin), .a(a_d[7:0]), .b(b_d[7:0]),
    .c(c_d[15:0]), .op(op_d), .out_valid(ov_w[2]), .p(p2), .ovf(ovf_w[2]));

  dsp_mac_pipe #(.SIGNED(0)) u3 (
    .clk(clk), .rst(rst), .en(en), .in_valid(vin), .a(a_d), .b(b_d), .c(c_d),
    .op(op_d), .out_valid(ov_w[3]), .p(p3), .ovf(ovf_w[3]));

  dsp_mac_pipe #(.AREG(0), .MREG(0)) u4 (
    .clk(clk), .rst(rst), .en(en), .in_valid(vin), .a(a_d), .b(b_d), .c(c_d),
    .op(op_d), .out_valid(ov_w[4]), .p(p4), .ovf(ovf_w[4]));

  dsp_mac_pipe #(.AREG(2)) u5 (
    .clk(clk), .rst(rst), .en(en), .in_valid(vin), .a(a_d), .b(b_d), .c(c_d),
    .op(op_d), .out_valid(ov_w[5]), .p(p5), .ovf(ovf_w[5]));

  int vectors = 0;
  int miscompares = 0;

  typedef struct { longint due; longint p; bit ovf; } sb_t;
  typedef struct { longint p; bit ovf; } cap_t;

  sb_t    sbq [NI][$];
  cap_t   cap [NI][$];
  longint acc [NI];
  bit     acc_ovf [NI];
  bit     ov_exp [NI];
  longint p_exp [NI];
  bit     ovf_exp [NI];
  longint ec = 0;

  function automatic longint ext(longint raw, int w, int s);
    longint msk;
    longint v;
    msk = (longint'(1) << w) - 1;
    v = raw & msk;
    if (s != 0 && v[w-1]) v = v - (longint'(1) << w);
    return v;
  endfunction

  function automatic logic [47:0] p_raw(int i);
    case (i)
      0: return p0;
      1: return {32'd0, p1};
      2: return {32'd0, p2};
      3: return p3;
      4: return p4;
      default: return p5;
    endcase
  endfunction

  function automatic longint pval(int i);
    return ext(longint'(p_raw(i)), PW_C[i], SG_C[i]);
  endfunction

  task automatic chk(string nm, longint act, longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      sbq[i].delete();
      acc[i] = 0;
      acc_ovf[i] = 1'b0;
      ov_exp[i] = 1'b0;
      p_exp[i] = 0;
      ovf_exp[i] = 1'b0;
    end
  endtask

  // Plain integer arithmetic: the new accumulator is known at issue time
  // because every op sees the result of the op issued just before it.
  task automatic model_issue();
    for (int i = 0; i < NI; i++) begin
      longint av, bv, cv, m, r, lo, hi, span;
      bit o;
      av = ext(longint'(a_d), AW_C[i], SG_C[i]);
      bv = ext(longint'(b_d), BW_C[i], SG_C[i]);
      cv = ext(longint'(c_d), CW_C[i], SG_C[i]);
      m  = av * bv;
      o  = acc_ovf[i];
      case (op_d)
        3'd0:    r = m;
        3'd1:    r = m + cv;
        3'd2:    r = acc[i] + m;
        3'd3:    r = acc[i] - m;
        3'd4:    r = cv - m;
        3'd5:    r = cv;
        3'd6:    r = 0;
        default: r = acc[i];
      endcase
      span = longint'(1) << PW_C[i];
      if (SG_C[i] != 0) begin
        lo = -(span / 2);
        hi = span / 2 - 1;
      end else begin
        lo = 0;
        hi = span - 1;
      end
      if (op_d <= 3'd4) begin
        o = (r < lo) || (r > hi);
        if (o) begin
          if (ST_C[i] != 0) begin
            r = (r < lo) ? lo : hi;
          end else begin
            r = r & (span - 1);
            if (SG_C[i] != 0 && r > hi) r = r - span;
          end
        end
      end else if (op_d != 3'd7) begin
        o = 1'b0;
      end
      acc[i] = r;
      acc_ovf[i] = o;
      sbq[i].push_back('{ec + LAT_C[i], r, o});
    end
  endtask

  task automatic step();
    bit was_en;
    was_en = en;
    @(posedge clk);
    #1;
    if (was_en && !rst) begin
      ec++;
      for (int i = 0; i < NI; i++) begin
        if (sbq[i].size() > 0 && sbq[i][0].due == ec) begin
          ov_exp[i]  = 1'b1;
          p_exp[i]   = sbq[i][0].p;
          ovf_exp[i] = sbq[i][0].ovf;
          void'(sbq[i].pop_front());
        end else begin
          ov_exp[i] = 1'b0;
        end
        if (ov_w[i]) cap[i].push_back('{pval(i), ovf_w[i]});
      end
    end
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("u%0d out_valid @%0d", i, ec), longint'(ov_w[i]), longint'(ov_exp[i]));
      chk($sformatf("u%0d p @%0d", i, ec), pval(i), p_exp[i]);
      chk($sformatf("u%0d ovf @%0d", i, ec), longint'(ovf_w[i]), longint'(ovf_exp[i]));
    end
  endtask

  task automatic cyc(bit e, bit v, logic [2:0] o, longint av, longint bv, longint cv);
    en   = e;
    vin  = v;
    op_d = o;
    a_d  = av[24:0];
    b_d  = bv[17:0];
    c_d  = cv[47:0];
    if (e && v) model_issue();
    step();
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 3'd0, 0, 0, 0);
  endtask

  task automatic check_reset(string tag);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s u%0d out_valid", tag, i), longint'(ov_w[i]), 0);
      chk($sformatf("%s u%0d p", tag, i), longint'(p_raw(i)), 0);
      chk($sformatf("%s u%0d ovf", tag, i), longint'(ovf_w[i]), 0);
    end
  endtask

  typedef struct {
    logic [2:0] op;
    longint     a;
    longint     b;
    longint     c;
    longint     exp_p;
    bit         exp_ovf;
  } vec_t;

  vec_t tv [11];

  task automatic run_table(bit stall);
    cap[0].delete();
    for (int k = 0; k < 11; k++) begin
      if (stall && k == 3) begin
        cyc(1'b0, 1'b1, 3'b010, 99, 99, 0);
        cyc(1'b0, 1'b1, 3'b010, 99, 99, 0);
      end
      cyc(1'b1, 1'b1, tv[k].op, tv[k].a, tv[k].b, tv[k].c);
    end
    idle(6);
    chk($sformatf("table stall=%0d result count", stall), longint'(cap[0].size()), 11);
    for (int k = 0; k < 11 && k < cap[0].size(); k++) begin
      chk($sformatf("table stall=%0d vec%0d p", stall, k), cap[0][k].p, tv[k].exp_p);
      chk($sformatf("table stall=%0d vec%0d ovf", stall, k), longint'(cap[0][k].ovf),
          longint'(tv[k].exp_ovf));
    end
  endtask

  initial begin
    tv[0]  = '{3'b110, 0, 0, 0, 0, 1'b0};
    tv[1]  = '{3'b010, 1, 2, 0, 2, 1'b0};
    tv[2]  = '{3'b010, 3, 4, 0, 14, 1'b0};
    tv[3]  = '{3'b010, -5, 6, 0, -16, 1'b0};
    tv[4]  = '{3'b010, 7, -1, 0, -23, 1'b0};
    tv[5]  = '{3'b011, 2, 2, 0, -27, 1'b0};
    tv[6]  = '{3'b000, 3, 4, 0, 12, 1'b0};
    tv[7]  = '{3'b001, 3, 4, 100, 112, 1'b0};
    tv[8]  = '{3'b100, 2, 3, 10, 4, 1'b0};
    tv[9]  = '{3'b101, 0, 0, -7, -7, 1'b0};
    tv[10] = '{3'b111, 0, 0, 0, -7, 1'b0};

    model_reset();
    #1 rst = 1'b1;
    #2 check_reset("power-on reset");
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // single op at default latency, then holds
    cyc(1'b1, 1'b1, 3'b000, 3, 4, 0);
    idle(4);
    chk("single op p", pval(0), 12);

    run_table(1'b0);
    run_table(1'b1);

    begin : ovf_seq
      longint e1 [5];
      longint e2 [5];
      bit     eo [5];
      e1 = '{0, 16129, 32258, 32767, 1};
      e2 = '{0, 16129, 32258, -17149, 1};
      eo = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      cap[1].delete();
      cap[2].delete();
      cyc(1'b1, 1'b1, 3'b110, 0, 0, 0);
      for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 3'b010, 127, 127, 0);
      cyc(1'b1, 1'b1, 3'b000, 1, 1, 0);
      idle(6);
      chk("sat result count", longint'(cap[1].size()), 5);
      chk("wrap result count", longint'(cap[2].size()), 5);
      for (int k = 0; k < 5 && k < cap[1].size(); k++) begin
        chk($sformatf("sat vec%0d p", k), cap[1][k].p, e1[k]);
        chk($sformatf("sat vec%0d ovf", k), longint'(cap[1][k].ovf), longint'(eo[k]));
      end
      for (int k = 0; k < 5 && k < cap[2].size(); k++) begin
        chk($sformatf("wrap vec%0d p", k), cap[2][k].p, e2[k]);
        chk($sformatf("wrap vec%0d ovf", k), longint'(cap[2][k].ovf), longint'(eo[k]));
      end
    end

    begin : unsigned_seq
      cap[3].delete();
      cyc(1'b1, 1'b1, 3'b001, 33554431, 1, 5);
      cyc(1'b1, 1'b1, 3'b100, 2, 3, 1);
      idle(6);
      chk("unsigned result count", longint'(cap[3].size()), 2);
      if (cap[3].size() == 2) begin
        chk("unsigned M+C p", cap[3][0].p, 33554436);
        chk("unsigned M+C ovf", longint'(cap[3][0].ovf), 0);
        chk("unsigned C-M p", cap[3][1].p, (longint'(1) << 48) - 5);
        chk("unsigned C-M ovf", longint'(cap[3][1].ovf), 1);
      end
    end

    // async reset with operations in flight
    cyc(1'b1, 1'b1, 3'b000, 5, 6, 0);
    cyc(1'b1, 1'b1, 3'b001, 7, 8, 9);
    rst = 1'b1;
    #2 check_reset("mid-op reset");
    model_reset();
    #1 rst = 1'b0;
    idle(8);

    begin : lat_seq
      int lat [NI];
      for (int i = 0; i < NI; i++) lat[i] = -1;
      cyc(1'b1, 1'b1, 3'b000, 3, 4, 0);
      for (int k = 1; k <= 8; k++) begin
        for (int i = 0; i < NI; i++) if (lat[i] < 0 && ov_w[i]) lat[i] = k;
        idle(1);
      end
      chk("latency default", longint'(lat[0]), 3);
      chk("latency AREG0 MREG0", longint'(lat[4]), 1);
      chk("latency AREG2", longint'(lat[5]), 4);
    end

    for (int k = 0; k < 600; k++) begin
      bit     e, v;
      longint av, bv, cv;
      e  = ($urandom_range(0, 99) < 85);
      v  = ($urandom_range(0, 99) < 80);
      av = longint'($urandom);
      bv = longint'($urandom);
      cv = {32'($urandom), 32'($urandom)};
      cyc(e, v, 3'($urandom_range(0, 7)), av, bv, cv);
    end
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dsp_mac_pipe.md
Name: dsp_mac_pipe

Overview:
Parametrised, pipelined multiply-accumulate slice. It is the generic successor to the fixed DSP48E1 direct-mode wrapper.
Configurable operand widths, input and multiplier pipeline depth, signedness and overflow handling. Opcode and C operand travel with the data, and a valid bit tracks each operation.
Used standalone or as the arithmetic core of FIR/dot-product engines in the Problem designs.

Parameters:
A_W, 25, width of operand a
B_W, 18, width of operand b
C_W, 48, width of operand c (C_W <= P_W)
P_W, 48, result/accumulator width (P_W >= A_W+B_W)
AREG, 1, input register stages for a/b/c/op/valid (0, 1 or 2)
MREG, 1, multiplier output register stages (0 or 1)
SIGNED, 1, 1 = two's-complement operands and result; 0 = unsigned
SATURATE, 0, 1 = clamp result on overflow; 0 = wrap modulo 2^P_W

Ports:
clk  in  1  clock, all registers update on rising edge
rst  in  1  asynchronous active-high reset
en  in  1  global clock enable; 0 freezes every register
in_valid  in  1  a/b/c/op are valid this cycle
a  in  A_W  operand A
b  in  B_W  operand B
c  in  C_W  operand C
op  in  3  operation select
out_valid  out  1  p holds the result of an accepted operation
p  out  P_W  result / accumulator register
ovf  out  1  overflow/saturation flag for the current p

Behaviour:
- Reset (async, rst=1): all pipeline valids, p and ovf go to 0 immediately. Data registers are cleared to 0. Operation resumes on the first clk edge after rst falls.
- Pipeline stages:
  - AREG input stages carry {a,b,c,op,in_valid}.
  - The multiplier forms a*b at full A_W+B_W width, sign- or zero-extended per SIGNED.
  - MREG stage carries {product, c, op, valid}.
  - The ALU stage writes the P register (always present).
- Latency: out_valid/p update AREG+MREG+1 enabled cycles after in_valid is sampled. Defaults give 3. With AREG=0, MREG=0 the latency is 1.
- Throughput: one operation per enabled cycle, with no back-pressure.
- en=0: every register, including P and the valid pipeline, holds. Inputs that cycle are ignored. Latency counts enabled cycles only.
- op encoding (M = extended product, C = c extended per SIGNED, P = current P register):
  - 000: P <= M
  - 001: P <= M + C
  - 010: P <= P + M (accumulate)
  - 011: P <= P - M
  - 100: P <= C - M
  - 101: P <= C (load)
  - 110: P <= 0 (clear)
  - 111: reserved; P holds and the op is treated as valid.
- The ALU writes P only when the valid bit reaching the ALU stage is 1. On invalid slots P, ovf and the accumulator hold, and out_valid drops to 0.
- Back-to-back accumulates: each op uses the P value written by the immediately preceding valid op (no hazard bubble).
- Arithmetic: the true result is computed in P_W+2 bits.
- Overflow: the true result lies outside [-2^(P_W-1), 2^(P_W-1)-1] (SIGNED=1) or outside [0, 2^P_W-1] (SIGNED=0).
  - SATURATE=0: p takes the low P_W bits (wrap) and ovf=1.
  - SATURATE=1: p is clamped to the nearest bound and ovf=1.
  - Ops 101/110 always give ovf=0.
- ovf is per-result, not sticky: each valid write recomputes it. It holds with p on invalid slots.
- Accumulating from a saturated p continues from the clamped value.
- p and ovf change only on valid writes. out_valid is a registered copy of the ALU-stage valid.

Test Plan:
- Defaults. a=3, b=4, op=000, single valid pulse -> out_valid=1 exactly 3 cycles later with p=12, ovf=0. Next cycle out_valid=0 and p holds 12.
- Accumulate stream:
  - Send op=110, then four consecutive op=010 with (a,b)=(1,2),(3,4),(-5,6),(7,-1).
  - -> p sequence 0, 2, 14, -16, -23 on consecutive cycles.
  - Then op=011 with (2,2) -> p=-27.
- Stall. During the same stream, hold en=0 for 2 cycles mid-stream -> identical p sequence, every result delayed by 2 cycles, no duplicated or lost op.
- Overflow with P_W=16, A_W=B_W=8 (SIGNED=1). op=110, then op=010 with (127,127) three times:
  - SATURATE=1 -> p=16129, 32258, then 32767 with ovf=1.
  - SATURATE=0 -> third p=-17149, ovf=1.
  - A following op=000 (1,1) -> p=1, ovf=0.
- Unsigned and C path with SIGNED=0: a=25'h1FFFFFF, b=1, c=5, op=001 -> p=33554436. Then op=100 with a=2, b=3, c=1 -> wrap to 2^48-5, ovf=1.
- Async reset mid-operation: assert rst between clk edges while 2 ops are in flight -> p=0, out_valid=0 and ovf=0 immediately. No results emerge after deassert until new in_valid. Repeat with AREG=0/MREG=0 and AREG=2 -> latency 1 and 4 respectively.
